// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory responder and its storage.
package cpu_mem_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_memory_responder_if.sv
// CPU memory bus plus boot-loader stream and status; master = CPU/loader side, slave = responder.
interface cpu_memory_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] memoryIn;
    logic [DW-1:0] memoryOut;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          cpu_hold;
    logic          rw_conflict;

    modport master (
        output read, write, address, memoryIn, ld_start, ld_valid, ld_data,
        input  memoryOut, ld_ready, ld_done, cpu_hold, rw_conflict
    );

    modport slave (
        input  read, write, address, memoryIn, ld_start, ld_valid, ld_data,
        output memoryOut, ld_ready, ld_done, cpu_hold, rw_conflict
    );
endinterface

// File: rtl/mem_array_16x8.sv
// Storage array: one synchronous write port, one combinational read port; no reset, contents persist.
module mem_array_16x8 #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_memory_responder.sv
// Memory responder with boot loader: zero-latency reads, write at the edge; loader stalls on ld_valid=0.
// CPU held in clear (cpu_hold) until a full image has been accepted.
module cpu_memory_responder
    import cpu_mem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int LOAD_WORDS = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    cpu_memory_responder_if.slave  bus
);
    localparam logic [AW:0] LAST_PTR = (AW+1)'(LOAD_WORDS - 1);

    state_t        state;
    logic [AW:0]   ld_ptr;
    logic          hold_q;
    logic          rdy_q;
    logic          done_q;
    logic          conflict_q;

    logic          ld_acc;
    logic          cpu_we;
    logic          cpu_rd;
    logic          cpu_conflict;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    assign ld_acc       = (state == ST_LOAD) && bus.ld_valid && rdy_q;
    assign cpu_we       = (state == ST_RUN) && bus.write && !bus.read;
    assign cpu_rd       = (state == ST_RUN) && bus.read && !bus.write;
    assign cpu_conflict = (state == ST_RUN) && bus.read && bus.write;

    // Loader owns the write port in LOAD, the CPU in RUN; never both.
    assign we    = ld_acc || cpu_we;
    assign waddr = (state == ST_LOAD) ? ld_ptr[AW-1:0] : bus.address;
    assign wdata = (state == ST_LOAD) ? bus.ld_data : bus.memoryIn;

    mem_array_16x8 #(.AW(AW), .DW(DW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (bus.address),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= ST_IDLE;
            ld_ptr     <= '0;
            hold_q     <= 1'b1;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cpu_conflict) begin
                conflict_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.ld_start) begin
                        state  <= ST_LOAD;
                        ld_ptr <= '0;
                        rdy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_acc) begin
                        ld_ptr <= ld_ptr + 1'b1;
                        if (ld_ptr == LAST_PTR) begin
                            state  <= ST_RUN;
                            hold_q <= 1'b0;
                            rdy_q  <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.ld_start) begin
                        state  <= ST_LOAD;
                        ld_ptr <= '0;
                        hold_q <= 1'b1;
                        rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    hold_q <= 1'b1;
                    rdy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.memoryOut   = cpu_rd ? rdata : '0;
    assign bus.ld_ready    = rdy_q;
    assign bus.ld_done     = done_q;
    assign bus.cpu_hold    = hold_q;
    assign bus.rw_conflict = conflict_q;
endmodule

// File: tb/tb_cpu_memory_responder.sv
// Directed bench for cpu_memory_responder: load, CPU read/write, conflict, reset mid-load, reload in RUN.
module tb_cpu_memory_responder;
    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   passes = 0;

    cpu_memory_responder_if #(.AW(4), .DW(8)) bus ();

    cpu_memory_responder #(.AW(4), .DW(8), .LOAD_WORDS(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    logic       ok;
    logic [7:0] v;

    initial begin
        clr = 1'b1;
        bus.read = 0; bus.write = 0; bus.address = '0; bus.memoryIn = '0;
        bus.ld_start = 0; bus.ld_valid = 0; bus.ld_data = '0;
        tick(); tick();
        clr = 1'b0;
        #1;
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_ready", bus.ld_ready, 0);
        chk("rst_done", bus.ld_done, 0);
        chk("rst_conflict", bus.rw_conflict, 0);
        chk("rst_memout", bus.memoryOut, 0);

        // 1: load 16 bytes with gaps
        bus.ld_start = 1; tick(); bus.ld_start = 0;
        chk("load_ready", bus.ld_ready, 1);
        chk("load_hold", bus.cpu_hold, 1);
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k % 3 == 1) begin
                bus.ld_valid = 0; tick();
                if (bus.ld_ready !== 1'b1 || bus.ld_done !== 1'b0) ok = 1'b0;
            end
            bus.ld_valid = 1; bus.ld_data = 8'h10 + 8'(k); tick();
            bus.ld_valid = 0;
            if (k < 15 && (bus.ld_done !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.ld_ready !== 1'b1)) ok = 1'b0;
        end
        chk("load_stream_flags", ok, 1);
        chk("done_pulse", bus.ld_done, 1);
        chk("run_hold", bus.cpu_hold, 0);
        chk("run_ready", bus.ld_ready, 0);
        tick();
        chk("done_cleared", bus.ld_done, 0);
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.read = 1; bus.address = 4'(k); #1;
            if (bus.memoryOut !== 8'h10 + 8'(k)) ok = 1'b0;
        end
        bus.read = 0;
        chk("loaded_contents", ok, 1);

        // 2: combinational read
        bus.read = 1; bus.address = 4'h5; #1;
        chk("read_5", bus.memoryOut, 8'h15);
        bus.read = 0; #1;
        chk("idle_bus", bus.memoryOut, 8'h00);

        // 3: write then read back
        bus.write = 1; bus.address = 4'hA; bus.memoryIn = 8'hC3; #1;
        chk("write_no_out", bus.memoryOut, 8'h00);
        tick();
        bus.write = 0; bus.read = 1; #1;
        chk("read_after_write", bus.memoryOut, 8'hC3);
        bus.read = 0;

        // 4: read/write conflict
        bus.read = 1; bus.write = 1; bus.address = 4'h2; bus.memoryIn = 8'hFF; #1;
        chk("conflict_out", bus.memoryOut, 8'h00);
        tick();
        chk("conflict_flag", bus.rw_conflict, 1);
        bus.write = 0; #1;
        chk("conflict_no_write", bus.memoryOut, 8'h12);
        bus.read = 0; tick(); tick();
        chk("conflict_sticky", bus.rw_conflict, 1);

        // 5: reset partway through a second load
        bus.ld_start = 1; tick(); bus.ld_start = 0;
        chk("reload_hold", bus.cpu_hold, 1);
        for (int k = 0; k < 7; k++) begin
            bus.ld_valid = 1; bus.ld_data = 8'hA0 + 8'(k); tick();
        end
        bus.ld_valid = 0;
        clr = 1; tick(); clr = 0;
        chk("midload_rst_hold", bus.cpu_hold, 1);
        chk("midload_rst_ready", bus.ld_ready, 0);
        chk("midload_rst_conflict", bus.rw_conflict, 0);
        ok = 1'b1;
        for (int k = 0; k < 7; k++)
            if (dut.u_mem.mem[k] !== 8'hA0 + 8'(k)) ok = 1'b0;
        chk("partial_load", ok, 1);
        chk("keep_7", dut.u_mem.mem[7], 8'h17);
        chk("keep_A", dut.u_mem.mem[10], 8'hC3);
        chk("keep_F", dut.u_mem.mem[15], 8'h1F);
        clr = 1; bus.ld_start = 1; tick(); clr = 0; bus.ld_start = 0;
        chk("rst_beats_start", bus.ld_ready, 0);

        // full reload restarting at address 0
        bus.ld_start = 1; tick(); bus.ld_start = 0;
        for (int k = 0; k < 16; k++) begin
            bus.ld_valid = 1; bus.ld_data = 8'h50 + 8'(k); tick();
        end
        bus.ld_valid = 0;
        chk("reload_done", bus.ld_done, 1);
        bus.read = 1; bus.address = 4'h0; #1;
        chk("reload_addr0", bus.memoryOut, 8'h50);
        bus.read = 0;

        // 6: ld_start in RUN with a concurrent CPU write
        bus.write = 1; bus.address = 4'h4; bus.memoryIn = 8'h77; bus.ld_start = 1; tick();
        bus.write = 0; bus.ld_start = 0;
        chk("restart_hold", bus.cpu_hold, 1);
        chk("restart_ready", bus.ld_ready, 1);
        chk("write_landed", dut.u_mem.mem[4], 8'h77);
        bus.read = 1; #1;
        chk("load_read_gated", bus.memoryOut, 8'h00);
        bus.read = 0; bus.write = 1; bus.address = 4'h9; bus.memoryIn = 8'hEE; tick();
        bus.read = 1; tick();
        bus.read = 0; bus.write = 0;
        chk("load_write_ignored", dut.u_mem.mem[9], 8'h59);
        chk("load_no_conflict", bus.rw_conflict, 0);
        bus.ld_valid = 1; bus.ld_data = 8'h99; tick();
        bus.ld_start = 1; bus.ld_data = 8'h98; tick();
        bus.ld_start = 0; bus.ld_valid = 0;
        chk("load_addr0", dut.u_mem.mem[0], 8'h99);
        chk("start_ignored_in_load", dut.u_mem.mem[1], 8'h98);
        v = dut.u_mem.mem[2];
        chk("untouched_2", v, 8'h52);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
